// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor: the controller state
// type and the default operand width.
// Ports: none (package).
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    // Default operand width; legal widths are 2..32.
    localparam int DEFAULT_WIDTH = 8;

    // IDLE  : waiting for an operand set, in_ready high
    // SHIFT : one bit processed per cycle, LSB first
    // DONE  : result presented with out_valid high until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor_using_hs.sv
// ---------------------------------------------------------------------------
// full_subtractor_using_hs
// One-bit full subtractor built from two cascaded half subtractors.
// Ports:
//   a    (in)  minuend bit
//   b    (in)  subtrahend bit
//   bin  (in)  borrow in
//   diff (out) a - b - bin, low bit
//   bout (out) borrow out
// ---------------------------------------------------------------------------
module full_subtractor_using_hs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic hs1_diff;
    logic hs1_borrow;
    logic hs2_borrow;

    // First half subtractor: a - b
    assign hs1_diff   = a ^ b;
    assign hs1_borrow = ~a & b;

    // Second half subtractor: (a - b) - bin
    assign diff       = hs1_diff ^ bin;
    assign hs2_borrow = ~hs1_diff & bin;

    // A borrow from either stage propagates out; both cannot occur together.
    assign bout = hs1_borrow | hs2_borrow;

endmodule : full_subtractor_using_hs

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor computing diff = a - b - bin (mod 2^WIDTH) and the
// MSB borrow, one bit per clock through a single full-subtractor cell.
// Ports:
//   clk       (in)  clock, rising edge
//   rst_n     (in)  asynchronous active-low reset
//   in_valid  (in)  upstream offers an operand set
//   in_ready  (out) block can accept an operand set (IDLE only)
//   a, b      (in)  minuend / subtrahend, WIDTH bits
//   bin       (in)  borrow-in applied to bit 0
//   out_valid (out) diff/bout hold a valid result (DONE only)
//   out_ready (in)  downstream accepts the result
//   diff      (out) result, WIDTH bits
//   bout      (out) borrow-out from the MSB
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // One extra counter bit so the count can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow;
    logic             bout_reg;
    logic [CW-1:0]    count;
    logic             cell_diff;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor_using_hs u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign last_bit = (count == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs depend on state only, so in_valid/out_ready never
    // reach an output combinationally.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = SHIFT;
            end
            SHIFT: begin
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The working shift register fills during SHIFT; the visible diff/bout
    // registers only update on the final bit so they hold the previous
    // result everywhere outside DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            shift_reg <= '0;
            diff_reg  <= '0;
            borrow    <= 1'b0;
            bout_reg  <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        borrow    <= bin;
                        shift_reg <= '0;
                        count     <= '0;
                    end
                end
                SHIFT: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    borrow    <= cell_bout;
                    shift_reg <= {cell_diff, shift_reg[WIDTH-1:1]};
                    count     <= count + 1'b1;
                    if (last_bit) begin
                        diff_reg <= {cell_diff, shift_reg[WIDTH-1:1]};
                        bout_reg <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results are
// pushed to a queue when an operand set is offered and popped when the DUT
// raises out_valid.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
    } result_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    result_t expected_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: W+1 bit subtraction, top bit is the borrow.
    function automatic result_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                      input logic mbin);
        logic [W:0] full;
        result_t    r;
        full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        r.diff = full[W-1:0];
        r.bout = full[W];
        return r;
    endfunction

    // Offer one operand set in the current (IDLE) cycle and push its result;
    // returns one negedge later, i.e. after the accept edge.
    task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin,
                        input bit push);
        a        = sa;
        b        = sb;
        bin      = sbin;
        in_valid = 1'b1;
        if (push) expected_q.push_back(model(sa, sb, sbin));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; cycles counts from the accept cycle (cycle 0).
    task automatic wait_valid(output int cycles, output bit ok);
        cycles = 1;
        ok     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_checks++;
        if (diff !== '0 || bout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_result got diff=%h bout=%b want 00/0", diff, bout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offered in the very first cycle after reset release.
    task automatic test_basic();
        int      cyc;
        bit      ok;
        result_t exp_r;
        send(8'h5A, 8'h3C, 1'b0, 1'b1);
        wait_valid(cyc, ok);
        n_checks++;
        if (!ok || cyc != W + 1) begin
            n_fail++;
            $display("[TB] FAIL basic_latency got %0d (seen=%0b) want %0d", cyc, ok, W + 1);
        end
        exp_r = expected_q.pop_front();
        n_checks++;
        if (diff !== exp_r.diff || bout !== exp_r.bout || diff !== 8'h1E) begin
            n_fail++;
            $display("[TB] FAIL basic_result got %h/%b want 1e/0", diff, bout);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL basic_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    // Underflow and borrow-in-only vectors.
    task automatic test_corner_cases();
        logic [W-1:0] ta [4] = '{8'h00, 8'hFF, 8'h00, 8'h80};
        logic [W-1:0] tb [4] = '{8'h01, 8'hFF, 8'h00, 8'h00};
        logic         tbi[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] td [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
        logic         tbo[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int      cyc;
        bit      ok;
        result_t exp_r;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb[i], tbi[i], 1'b1);
            wait_valid(cyc, ok);
            exp_r = expected_q.pop_front();
            n_checks++;
            if (!ok || diff !== exp_r.diff || bout !== exp_r.bout
                || diff !== td[i] || bout !== tbo[i]) begin
                n_fail++;
                $display("[TB] FAIL corner_%0d got %h/%b want %h/%b (seen=%0b)",
                         i, diff, bout, td[i], tbo[i], ok);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int      cyc;
        bit      ok;
        result_t exp_r;
        out_ready = 1'b0;
        send(8'hC3, 8'h5D, 1'b1, 1'b1);
        wait_valid(cyc, ok);
        exp_r = expected_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL bp_timeout got no out_valid want out_valid");
        end
        for (int i = 0; i < 5; i++) begin
            // Stray offers in DONE must be ignored.
            in_valid = i[0];
            a        = 8'h11 + 8'(i);
            b        = 8'h22;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0
                || diff !== exp_r.diff || bout !== exp_r.bout) begin
                n_fail++;
                $display("[TB] FAIL bp_hold_%0d got v=%b r=%b %h/%b want 1/0 %h/%b",
                         i, out_valid, in_ready, diff, bout, exp_r.diff, exp_r.bout);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_release got v=%b r=%b want 0/1", out_valid, in_ready);
        end
        repeat (W + 3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_no_extra got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int      cyc;
        bit      ok;
        int      spurious;
        result_t exp_r;
        out_ready = 1'b1;
        send(8'h33, 8'h11, 1'b0, 1'b0);
        // Now in SHIFT cycle 1; advance to cycle 4.
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || bout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset got v=%b r=%b %h/%b want 0/1 00/0",
                     out_valid, in_ready, diff, bout);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("[TB] FAIL mid_no_result got %0d valid cycles want 0", spurious);
        end
        send(8'h10, 8'h01, 1'b0, 1'b1);
        wait_valid(cyc, ok);
        exp_r = expected_q.pop_front();
        n_checks++;
        if (!ok || diff !== exp_r.diff || bout !== exp_r.bout || diff !== 8'h0F) begin
            n_fail++;
            $display("[TB] FAIL mid_after got %h/%b want 0f/0 (seen=%0b)", diff, bout, ok);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] na [16];
        logic [W-1:0] nb [16];
        logic         nbi[16];
        int      sent      = 0;
        int      received  = 0;
        int      last_out  = -1;
        int      cyc       = 0;
        bit      load_next = 1'b0;
        result_t exp_r;
        for (int i = 0; i < 16; i++) begin
            na[i]  = W'($urandom);
            nb[i]  = W'($urandom);
            nbi[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        a         = na[0];
        b         = nb[0];
        bin       = nbi[0];
        in_valid  = 1'b1;
        while (received < 16 && cyc < 16 * (W + 2) + 50) begin
            if (load_next) begin
                load_next = 1'b0;
                if (sent < 16) begin
                    a   = na[sent];
                    b   = nb[sent];
                    bin = nbi[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                exp_r = expected_q.pop_front();
                n_checks++;
                if (diff !== exp_r.diff || bout !== exp_r.bout) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_result_%0d got %h/%b want %h/%b",
                             received, diff, bout, exp_r.diff, exp_r.bout);
                end
                if (last_out >= 0) begin
                    n_checks++;
                    if (cyc - last_out != W + 2) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_period_%0d got %0d want %0d",
                                 received, cyc - last_out, W + 2);
                    end
                end
                last_out = cyc;
                received++;
            end
            if (in_ready === 1'b1 && in_valid === 1'b1) begin
                expected_q.push_back(model(a, b, bin));
                sent++;
                load_next = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (received != 16) begin
            n_fail++;
            $display("[TB] FAIL b2b_count got %0d want 16", received);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_corner_cases();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream offers an operand set.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-006 SHALL have port a, input, WIDTH bits: minuend.
REQ-007 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 SHALL have port bin, input, 1 bit: borrow-in applied to bit 0.
REQ-009 SHALL have port out_valid, output, 1 bit: diff/bout hold a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout, output, 1 bit: borrow-out from the MSB (1 when a < b + bin).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; encoding free.
REQ-014 In IDLE: in_ready=1; on in_valid=1, SHALL capture a, b, bin, clear bit counter, and go to SHIFT.
REQ-015 In SHIFT: SHALL process one bit per cycle, LSB first, through one full-subtractor cell; the cell takes current a bit, current b bit, and the registered borrow.
REQ-016 In SHIFT: diff bit SHALL shift into result register MSB side; borrow register SHALL update; operands SHALL shift right by one.
REQ-017 After exactly WIDTH SHIFT cycles, SHALL go to DONE with out_valid=1; latency from accept edge to out_valid high is WIDTH+1 cycles.
REQ-018 In DONE: diff and bout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 In DONE with out_ready=1: SHALL return to IDLE next cycle; out_valid low next cycle.
REQ-020 in_ready SHALL be 0 in SHIFT and DONE; in_valid there SHALL be ignored; no overlap between results.
REQ-021 in_valid and out_ready SHALL have no combinational path to any output.
REQ-022 Bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap during an operation.
REQ-023 diff and bout outside DONE SHALL hold the last result; only out_valid qualifies them.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid=0, in_ready=1, diff=0, bout=0, and clear counter, operand, and borrow registers.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no result emitted after release.
REQ-026 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-028 The per-bit cell SHALL reuse the existing full_subtractor_using_hs as the single sub-module, instantiated once.
REQ-029 The per-bit cell SHALL be the only subtraction logic; no WIDTH-bit parallel subtractor.

Verification
REQ-030 Basic case, WIDTH=8: a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0, out_valid exactly 9 cycles after accept.
REQ-031 Underflow cases: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-032 Borrow-in only: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; a=0x80, b=0x00, bin=1 -> diff=0x7F, bout=0.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff/bout stable, in_ready=0 throughout; in_valid pulses ignored.
REQ-034 Reset mid-operation: assert rst_n low at SHIFT cycle 4 -> outputs reach reset values with no clock edge; no out_valid after release. Then a=0x10, b=0x01 -> diff=0x0F, bout=0.
REQ-035 Back-to-back transfers: out_ready=1 and in_valid=1 held high -> one result every WIDTH+2 cycles; 16 random pairs match a-b-bin.
